// File: rtl/tdc_meas_seq.sv
// Host-side TDC measurement sequencer: drives launch/capture/valid pins and accumulates returned Hamming weights.
// Optional min/max tracking of accepted samples is enabled by defining TDC_SEQ_MINMAX_EN.
module tdc_meas_seq #(
    parameter int N       = 64,
    parameter int DLY_W   = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 15,
    localparam int HW_W   = $clog2(N) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [DLY_W-1:0]        cfg_delay_i,
    input  logic [CNT_W-1:0]        cfg_count_i,
    input  logic [3:0]              cfg_pg_i,
    output logic                    clk_launch_o,
    output logic                    clk_capture_o,
    output logic                    val_in_o,
    output logic                    pg_src_o,
    output logic                    pg_bypass_o,
    output logic                    pg_in_o,
    output logic                    pg_tog_o,
    input  logic [HW_W-1:0]         tdc_hw_i,
    input  logic                    tdc_val_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_timeout_o,
    output logic [HW_W+CNT_W-1:0]   acc_o,
    output logic [CNT_W-1:0]        n_valid_o
`ifdef TDC_SEQ_MINMAX_EN
    ,
    output logic [HW_W-1:0]         hw_min_o,
    output logic [HW_W-1:0]         hw_max_o
`endif
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int ACC_W = HW_W + CNT_W;

    typedef enum logic [2:0] {
        IDLE, ARM, LAUNCH, DELAY, WAIT_V, RELEASE, WAIT_NV, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [DLY_W-1:0]   dly_q, dly_d, cnt_q, cnt_d;
    logic [CNT_W-1:0]   rem_q, rem_d, nv_q, nv_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [3:0]         pg_q, pg_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               launch_q, launch_d, capture_q, capture_d, val_in_q, val_in_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               val_s1_q, val_s_q;
    logic [HW_W-1:0]    min_q, min_d, max_q, max_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            dly_q     <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            nv_q      <= '0;
            tmo_q     <= '0;
            pg_q      <= '0;
            acc_q     <= '0;
            launch_q  <= 1'b0;
            capture_q <= 1'b0;
            val_in_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            val_s1_q  <= 1'b0;
            val_s_q   <= 1'b0;
            min_q     <= '0;
            max_q     <= '0;
        end else begin
            state_q   <= state_d;
            dly_q     <= dly_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            nv_q      <= nv_d;
            tmo_q     <= tmo_d;
            pg_q      <= pg_d;
            acc_q     <= acc_d;
            launch_q  <= launch_d;
            capture_q <= capture_d;
            val_in_q  <= val_in_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            val_s1_q  <= tdc_val_i;
            val_s_q   <= val_s1_q;
            min_q     <= min_d;
            max_q     <= max_d;
        end
    end

    // Pin-level outputs change on entry to the state that owns them, so every TDC-side signal is a flop.
    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        nv_d      = nv_q;
        tmo_d     = tmo_q;
        pg_d      = pg_q;
        acc_d     = acc_q;
        launch_d  = launch_q;
        capture_d = capture_q;
        val_in_d  = val_in_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        min_d     = min_q;
        max_d     = max_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    dly_d  = cfg_delay_i;
                    rem_d  = cfg_count_i;
                    pg_d   = cfg_pg_i;
                    acc_d  = '0;
                    nv_d   = '0;
                    err_d  = 1'b0;
                    min_d  = '1;
                    max_d  = '0;
                    busy_d = 1'b1;
                    if (cfg_count_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = ARM;
                        val_in_d = 1'b1;
                    end
                end
            end
            ARM: begin
                state_d  = LAUNCH;
                launch_d = 1'b1;
                cnt_d    = dly_q;
            end
            // Capture is raised when the counter reaches zero, giving cfg_delay+1 cycles after launch.
            LAUNCH: begin
                state_d = DELAY;
                if (cnt_q == '0) capture_d = 1'b1;
            end
            DELAY: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_V;
                    tmo_d   = '0;
                end else begin
                    cnt_d = cnt_q - DLY_W'(1);
                    if (cnt_q == DLY_W'(1)) capture_d = 1'b1;
                end
            end
            WAIT_V: begin
                if (val_s_q || tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    if (val_s_q) begin
                        acc_d = acc_q + ACC_W'(tdc_hw_i);
                        nv_d  = nv_q + CNT_W'(1);
                        if (tdc_hw_i < min_q) min_d = tdc_hw_i;
                        if (tdc_hw_i > max_q) max_d = tdc_hw_i;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d   = RELEASE;
                    val_in_d  = 1'b0;
                    launch_d  = 1'b0;
                    capture_d = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            RELEASE: begin
                state_d = WAIT_NV;
                tmo_d   = '0;
            end
            WAIT_NV: begin
                if (!val_s_q || tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    if (val_s_q) err_d = 1'b1;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d  = ARM;
                        val_in_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign clk_launch_o  = launch_q;
    assign clk_capture_o = capture_q;
    assign val_in_o      = val_in_q;
    assign pg_src_o      = pg_q[0];
    assign pg_bypass_o   = pg_q[1];
    assign pg_in_o       = pg_q[2];
    assign pg_tog_o      = pg_q[3];
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_timeout_o = err_q;
    assign acc_o         = acc_q;
    assign n_valid_o     = nv_q;
`ifdef TDC_SEQ_MINMAX_EN
    assign hw_min_o      = min_q;
    assign hw_max_o      = max_q;
`endif

endmodule

// File: tb/tb_tdc_meas_seq.sv
// Directed bench for tdc_meas_seq with a behavioural TDC that answers each capture edge from a per-sample table.
module tb_tdc_meas_seq;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [7:0]  cfg_delay_i;
    logic [7:0]  cfg_count_i;
    logic [3:0]  cfg_pg_i;
    logic        clk_launch_o, clk_capture_o, val_in_o;
    logic        pg_src_o, pg_bypass_o, pg_in_o, pg_tog_o;
    logic [6:0]  tdc_hw_i;
    logic        tdc_val_i;
    logic        busy_o, done_o, err_timeout_o;
    logic [14:0] acc_o;
    logic [7:0]  n_valid_o;
`ifdef TDC_SEQ_MINMAX_EN
    logic [6:0]  hw_min_o, hw_max_o;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [6:0] hw_tab [64];
    bit         mute_tab [64];
    int         samp = 0;

    always #5 clk_i = ~clk_i;

    tdc_meas_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .cfg_delay_i(cfg_delay_i), .cfg_count_i(cfg_count_i), .cfg_pg_i(cfg_pg_i),
        .clk_launch_o(clk_launch_o), .clk_capture_o(clk_capture_o), .val_in_o(val_in_o),
        .pg_src_o(pg_src_o), .pg_bypass_o(pg_bypass_o), .pg_in_o(pg_in_o), .pg_tog_o(pg_tog_o),
        .tdc_hw_i(tdc_hw_i), .tdc_val_i(tdc_val_i),
        .busy_o(busy_o), .done_o(done_o), .err_timeout_o(err_timeout_o),
        .acc_o(acc_o), .n_valid_o(n_valid_o)
`ifdef TDC_SEQ_MINMAX_EN
        , .hw_min_o(hw_min_o), .hw_max_o(hw_max_o)
`endif
    );

    // TDC model: valid rises with capture (unless muted for that sample) and falls with val_in.
    always @(posedge clk_capture_o or negedge val_in_o) begin
        if (!val_in_o) begin
            tdc_val_i = 1'b0;
        end else begin
            if (!mute_tab[samp % 64]) begin
                tdc_hw_i  = hw_tab[samp % 64];
                tdc_val_i = 1'b1;
            end
            samp = samp + 1;
        end
    end

    task automatic set_sample(input int k, input logic [6:0] hw, input bit mute);
        hw_tab[(samp + k) % 64]   = hw;
        mute_tab[(samp + k) % 64] = mute;
    endtask

    task automatic do_start(input logic [7:0] d, input logic [7:0] c, input logic [3:0] pg);
        cfg_delay_i = d;
        cfg_count_i = c;
        cfg_pg_i    = pg;
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcnt);
        int post;
        dcnt = 0;
        post = 0;
        for (int i = 0; i < budget && post < 4; i++) begin
            @(negedge clk_i);
            if (done_o) dcnt++;
            if (dcnt != 0) post++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        total_cnt++;
        if ({clk_launch_o, clk_capture_o, val_in_o, pg_src_o, pg_bypass_o, pg_in_o, pg_tog_o,
             busy_o, done_o, err_timeout_o} !== 10'b0) begin
            $display("FAIL reset_ctrl: got %b want 0", {clk_launch_o, clk_capture_o, val_in_o,
                     pg_src_o, pg_bypass_o, pg_in_o, pg_tog_o, busy_o, done_o, err_timeout_o});
        end else pass_cnt++;
        total_cnt++;
        if ({acc_o, n_valid_o} !== 23'b0) $display("FAIL reset_acc: got %0d/%0d want 0/0", acc_o, n_valid_o);
        else pass_cnt++;
`ifdef TDC_SEQ_MINMAX_EN
        total_cnt++;
        if ({hw_min_o, hw_max_o} !== 14'b0) $display("FAIL reset_minmax: got %0d/%0d want 0/0", hw_min_o, hw_max_o);
        else pass_cnt++;
`endif
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_basic();
        int dcnt;
        set_sample(0, 7'd10, 0);
        set_sample(1, 7'd20, 0);
        set_sample(2, 7'd30, 0);
        set_sample(3, 7'd40, 0);
        do_start(8'd3, 8'd4, 4'b1010);
        total_cnt++;
        if ({busy_o, val_in_o, clk_launch_o} !== 3'b110)
            $display("FAIL basic_after_E0: busy/val_in/launch got %b want 110", {busy_o, val_in_o, clk_launch_o});
        else pass_cnt++;
        total_cnt++;
        if ({pg_tog_o, pg_in_o, pg_bypass_o, pg_src_o} !== 4'b1010)
            $display("FAIL basic_pg: got %b want 1010", {pg_tog_o, pg_in_o, pg_bypass_o, pg_src_o});
        else pass_cnt++;
        wait_done(400, dcnt);
        total_cnt++;
        if (dcnt !== 1) $display("FAIL basic_done_pulses: got %0d want 1", dcnt);
        else pass_cnt++;
        total_cnt++;
        if (acc_o !== 15'd100) $display("FAIL basic_acc: got %0d want 100", acc_o);
        else pass_cnt++;
        total_cnt++;
        if (n_valid_o !== 8'd4) $display("FAIL basic_n_valid: got %0d want 4", n_valid_o);
        else pass_cnt++;
        total_cnt++;
        if ({err_timeout_o, busy_o} !== 2'b00) $display("FAIL basic_err_busy: got %b want 00", {err_timeout_o, busy_o});
        else pass_cnt++;
`ifdef TDC_SEQ_MINMAX_EN
        total_cnt++;
        if ({hw_min_o, hw_max_o} !== {7'd10, 7'd40}) $display("FAIL basic_minmax: got %0d/%0d want 10/40", hw_min_o, hw_max_o);
        else pass_cnt++;
`endif
        repeat (5) @(negedge clk_i);
        total_cnt++;
        if ({acc_o, n_valid_o} !== {15'd100, 8'd4}) $display("FAIL basic_hold: got %0d/%0d want 100/4", acc_o, n_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_delay(input logic [7:0] d);
        int cyc, launch_at, cap_at;
        set_sample(0, 7'd1, 0);
        do_start(d, 8'd1, 4'b0000);
        cyc = 0;
        launch_at = -1;
        cap_at = -1;
        for (int i = 0; i < 300 && !done_o; i++) begin
            @(negedge clk_i);
            cyc++;
            if (clk_launch_o && launch_at < 0) launch_at = cyc;
            if (clk_capture_o && cap_at < 0) cap_at = cyc;
        end
        total_cnt++;
        if (launch_at !== 1) $display("FAIL delay%0d_launch_at: got %0d want 1", d, launch_at);
        else pass_cnt++;
        total_cnt++;
        if (cap_at - launch_at !== int'(d) + 1)
            $display("FAIL delay%0d_spacing: got %0d want %0d", d, cap_at - launch_at, int'(d) + 1);
        else pass_cnt++;
        total_cnt++;
        if ({done_o, acc_o} !== {1'b1, 15'd1}) $display("FAIL delay%0d_result: done/acc got %b/%0d want 1/1", d, done_o, acc_o);
        else pass_cnt++;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_timeout();
        int dcnt;
        set_sample(0, 7'd7, 0);
        set_sample(1, 7'd7, 1);
        set_sample(2, 7'd7, 0);
        do_start(8'd2, 8'd3, 4'b0001);
        wait_done(500, dcnt);
        total_cnt++;
        if (dcnt !== 1) $display("FAIL timeout_done: got %0d want 1", dcnt);
        else pass_cnt++;
        total_cnt++;
        if (err_timeout_o !== 1'b1) $display("FAIL timeout_err: got %b want 1", err_timeout_o);
        else pass_cnt++;
        total_cnt++;
        if (n_valid_o !== 8'd2) $display("FAIL timeout_n_valid: got %0d want 2", n_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (acc_o !== 15'd14) $display("FAIL timeout_acc: got %0d want 14", acc_o);
        else pass_cnt++;
    endtask

    task automatic test_count_zero();
        do_start(8'd4, 8'd0, 4'b0000);
        total_cnt++;
        if ({busy_o, done_o} !== 2'b10) $display("FAIL zero_after_E0: busy/done got %b want 10", {busy_o, done_o});
        else pass_cnt++;
        @(negedge clk_i);
        total_cnt++;
        if ({busy_o, done_o} !== 2'b01) $display("FAIL zero_at_E1: busy/done got %b want 01", {busy_o, done_o});
        else pass_cnt++;
        total_cnt++;
        if ({acc_o, n_valid_o, err_timeout_o} !== 24'b0)
            $display("FAIL zero_results: acc/n/err got %0d/%0d/%b want 0/0/0", acc_o, n_valid_o, err_timeout_o);
        else pass_cnt++;
`ifdef TDC_SEQ_MINMAX_EN
        total_cnt++;
        if ({hw_min_o, hw_max_o} !== {7'h7f, 7'd0}) $display("FAIL zero_minmax: got %0d/%0d want 127/0", hw_min_o, hw_max_o);
        else pass_cnt++;
`endif
        @(negedge clk_i);
        total_cnt++;
        if (done_o !== 1'b0) $display("FAIL zero_done_width: got %b want 0", done_o);
        else pass_cnt++;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        int dcnt;
        set_sample(0, 7'd5, 0);
        set_sample(1, 7'd6, 0);
        set_sample(2, 7'd50, 0);
        set_sample(3, 7'd50, 0);
        do_start(8'd1, 8'd2, 4'b0100);
        repeat (4) @(negedge clk_i);
        do_start(8'd9, 8'd3, 4'b0011);
        repeat (6) @(negedge clk_i);
        do_start(8'd9, 8'd3, 4'b0011);
        wait_done(400, dcnt);
        total_cnt++;
        if (dcnt !== 1) $display("FAIL busy_start_done: got %0d want 1", dcnt);
        else pass_cnt++;
        total_cnt++;
        if ({acc_o, n_valid_o} !== {15'd11, 8'd2}) $display("FAIL busy_start_result: got %0d/%0d want 11/2", acc_o, n_valid_o);
        else pass_cnt++;
        total_cnt++;
        if ({err_timeout_o, pg_tog_o, pg_in_o, pg_bypass_o, pg_src_o} !== 5'b00100)
            $display("FAIL busy_start_err_pg: got %b want 00100", {err_timeout_o, pg_tog_o, pg_in_o, pg_bypass_o, pg_src_o});
        else pass_cnt++;
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL busy_start_idle: got %b want 0", busy_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int dcnt;
        set_sample(0, 7'd9, 0);
        do_start(8'd20, 8'd2, 4'b1111);
        repeat (6) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        total_cnt++;
        if ({clk_launch_o, clk_capture_o, val_in_o, busy_o, done_o, err_timeout_o} !== 6'b0)
            $display("FAIL midrst_ctrl: got %b want 0", {clk_launch_o, clk_capture_o, val_in_o, busy_o, done_o, err_timeout_o});
        else pass_cnt++;
        total_cnt++;
        if ({pg_tog_o, pg_in_o, pg_bypass_o, pg_src_o} !== 4'b0)
            $display("FAIL midrst_pg: got %b want 0000", {pg_tog_o, pg_in_o, pg_bypass_o, pg_src_o});
        else pass_cnt++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        do_start(8'd2, 8'd1, 4'b0000);
        wait_done(300, dcnt);
        total_cnt++;
        if (dcnt !== 1) $display("FAIL midrst_rerun_done: got %0d want 1", dcnt);
        else pass_cnt++;
        total_cnt++;
        if ({acc_o, n_valid_o, err_timeout_o} !== {15'd9, 8'd1, 1'b0})
            $display("FAIL midrst_rerun_result: got %0d/%0d/%b want 9/1/0", acc_o, n_valid_o, err_timeout_o);
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            hw_tab[i]   = 7'd0;
            mute_tab[i] = 1'b0;
        end
        tdc_hw_i    = 7'd0;
        tdc_val_i   = 1'b0;
        start_i     = 1'b0;
        cfg_delay_i = 8'd0;
        cfg_count_i = 8'd0;
        cfg_pg_i    = 4'd0;
        rst_ni      = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_basic();
        test_delay(8'd0);
        test_delay(8'd5);
        test_timeout();
        test_count_zero();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
